// File: rtl/chk_arr.sv
// chk_arr: snapshot-and-scan comparator for a packed array of channels.
// On an accepted check request the observed (sig) and reference (rfr)
// arrays are captured, then one channel is compared per clock, in order
// 0..CHANNELS-1. Completion is flagged with a one-cycle done pulse, and
// pass, err_count, err_valid and first_err are held until the next
// accepted request.
// Optional feature: define CHK_ARR_MASK_EN to add a per-channel mask port.
// A masked channel is excluded from counting. The mask is captured
// together with sig and rfr.
module chk_arr #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 6,
    localparam int unsigned IDXW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNTW    = $clog2(CHANNELS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        check,
    input  logic [CHANNELS*WIDTH-1:0]   sig,
    input  logic [CHANNELS*WIDTH-1:0]   rfr,
`ifdef CHK_ARR_MASK_EN
    input  logic [CHANNELS-1:0]         mask,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [CNTW-1:0]             err_count,
    output logic                        err_valid,
    output logic [IDXW-1:0]             first_err
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [DW-1:0]     sig_q, sig_d;
    logic [DW-1:0]     rfr_q, rfr_d;
    logic [IDXW-1:0]   idx, idx_d;
    logic [CNTW-1:0]   cnt_d;
    logic              valid_d;
    logic [IDXW-1:0]   first_d;
    logic              pass_d;
    logic              busy_d;
    logic              done_d;
    logic              hit_c;
    logic              last_c;
    logic [CHANNELS-1:0] mask_q, mask_d;

    // Channel under comparison this cycle and whether it counts as a mismatch
    always_comb begin
        hit_c  = (sig_q[idx * WIDTH +: WIDTH] != rfr_q[idx * WIDTH +: WIDTH])
                 && !mask_q[idx];
        last_c = (idx == IDXW'(CHANNELS - 1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        sig_d   = sig_q;
        rfr_d   = rfr_q;
        mask_d  = mask_q;
        idx_d   = idx;
        cnt_d   = err_count;
        valid_d = err_valid;
        first_d = first_err;
        pass_d  = pass;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (check) begin
                    sig_d   = sig;
                    rfr_d   = rfr;
`ifdef CHK_ARR_MASK_EN
                    mask_d  = mask;
`else
                    mask_d  = '0;
`endif
                    idx_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                if (hit_c) begin
                    // err_count saturates at CHANNELS; it cannot wrap
                    if (err_count != CNTW'(CHANNELS)) begin
                        cnt_d = err_count + CNTW'(1);
                    end
                    if (!err_valid) begin
                        valid_d = 1'b1;
                        first_d = idx;
                    end
                end
                if (last_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    idx_d = idx + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, snapshot and output registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sig_q     <= '0;
            rfr_q     <= '0;
            mask_q    <= '0;
            idx       <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_err <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            sig_q     <= sig_d;
            rfr_q     <= rfr_d;
            mask_q    <= mask_d;
            idx       <= idx_d;
            err_count <= cnt_d;
            err_valid <= valid_d;
            first_err <= first_d;
            pass      <= pass_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_chk_arr.sv
// tb_chk_arr: directed self-checking bench for chk_arr (WIDTH=4, CHANNELS=6).
module tb_chk_arr;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 6;

    logic        clk;
    logic        reset;
    logic        check;
    logic [23:0] sig;
    logic [23:0] rfr;
    logic [5:0]  mask;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  err_count;
    logic        err_valid;
    logic [2:0]  first_err;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [23:0] BASE = 24'h5A3C91;
    localparam logic [23:0] ALT25 = 24'h4A3391;   // channels 2 and 5 differ
    localparam logic [23:0] ALT2  = 24'h5A3D91;   // channel 2 differs

    chk_arr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .reset     (reset),
        .check     (check),
        .sig       (sig),
        .rfr       (rfr),
`ifdef CHK_ARR_MASK_EN
        .mask      (mask),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_valid (err_valid),
        .first_err (first_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic ep, input logic [2:0] ec,
                           input logic ev, input logic [2:0] ef);
        chk({tag, " pass"}, 32'(pass), 32'(ep));
        chk({tag, " err_count"}, 32'(err_count), 32'(ec));
        chk({tag, " err_valid"}, 32'(err_valid), 32'(ev));
        if (ev) chk({tag, " first_err"}, 32'(first_err), 32'(ef));
    endtask

    // Pulse check, follow the 6-cycle scan, check the done edge and result
    task automatic run_scan(input string tag, input logic ep, input logic [2:0] ec,
                            input logic ev, input logic [2:0] ef);
        check = 1'b1;
        tick();
        check = 1'b0;
        chk({tag, " busy@accept"}, 32'(busy), 32'd1);
        chk({tag, " cnt@accept"}, 32'(err_count), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                chk({tag, " busy mid"}, 32'(busy), 32'd1);
                chk({tag, " done mid"}, 32'(done), 32'd0);
            end
        end
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " done@done"}, 32'(done), 32'd1);
        chk_res(tag, ep, ec, ev, ef);
    endtask

    initial begin
        reset = 1'b1;
        check = 1'b0;
        sig   = '0;
        rfr   = '0;
        mask  = '0;

        // Reset for two cycles: everything low
        tick();
        tick();
        reset = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk_res("rst", 1'b0, 3'd0, 1'b0, 3'd0);
        chk("rst first_err", 32'(first_err), 32'd0);

        // Matching arrays
        sig = BASE;
        rfr = BASE;
        run_scan("match", 1'b1, 3'd0, 1'b0, 3'd0);
        tick();
        chk("match done drop", 32'(done), 32'd0);
        chk("match busy idle", 32'(busy), 32'd0);

        // Channels 2 and 5 differ; results held over 10 idle cycles
        rfr = ALT25;
        run_scan("mm", 1'b0, 3'd2, 1'b1, 3'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold done", 32'(done), 32'd0);
            chk_res("hold", 1'b0, 3'd2, 1'b1, 3'd2);
        end

        // Check re-pulsed and sig toggled mid-scan: ignored
        check = 1'b1;
        tick();
        check = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            sig   = (i == 2) ? ~BASE : sig;
            check = (i == 3);
            tick();
            check = 1'b0;
            if (i < 6) chk("ign busy", 32'(busy), 32'd1);
        end
        chk("ign done", 32'(done), 32'd1);
        chk_res("ign", 1'b0, 3'd2, 1'b1, 3'd2);

        // Check held through DONE restarts a scan on the next edge
        sig   = BASE;
        check = 1'b1;
        tick();
        check = 1'b0;
        chk("restart busy", 32'(busy), 32'd1);
        chk("restart done", 32'(done), 32'd0);
        chk("restart cnt clr", 32'(err_count), 32'd0);
        for (int i = 1; i <= 6; i++) tick();
        chk("restart done pulse", 32'(done), 32'd1);
        chk_res("restart", 1'b0, 3'd2, 1'b1, 3'd2);
        tick();

        // Reset at scan cycle 3 of a mismatching scan
        check = 1'b1;
        tick();
        check = 1'b0;
        tick();
        tick();
        tick();
        chk("abort cnt@3", 32'(err_count), 32'd1);
        chk("abort valid@3", 32'(err_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk_res("abort", 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort no done", 32'(done), 32'd0);
            chk("abort idle busy", 32'(busy), 32'd0);
        end

        // Reset has priority over check in the same cycle
        reset = 1'b1;
        check = 1'b1;
        tick();
        reset = 1'b0;
        check = 1'b0;
        chk("prio busy", 32'(busy), 32'd0);
        tick();
        chk("prio busy2", 32'(busy), 32'd0);

        // Channel 2 mismatch with channel 2 masked
        sig  = BASE;
        rfr  = ALT2;
        mask = 6'b000100;
`ifdef CHK_ARR_MASK_EN
        run_scan("mask", 1'b1, 3'd0, 1'b0, 3'd0);
`else
        run_scan("mask", 1'b0, 3'd1, 1'b1, 3'd2);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
